// File: rtl/ps2_tx.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module   : ps2_tx
// Brief    : PS/2 host-to-device byte transmitter (open-drain oe outputs).
// Revision : 1.0 - initial release
// ============================================================================
module ps2_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int FILTER_WIDTH   = 3,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       done,
  output logic       err
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [INH_W-1:0]        INH_LAST  = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [TO_W-1:0]         TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [FILTER_WIDTH-1:0] FILT_LAST = FILTER_WIDTH'((2 ** FILTER_WIDTH) - 2);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_INHIBIT   = 3'd1;
  localparam logic [2:0] ST_START     = 3'd2;
  localparam logic [2:0] ST_DATA      = 3'd3;
  localparam logic [2:0] ST_PARITY    = 3'd4;
  localparam logic [2:0] ST_STOP      = 3'd5;
  localparam logic [2:0] ST_ACK       = 3'd6;
  localparam logic [2:0] ST_WAIT_IDLE = 3'd7;

  logic                    clk_s1_q, clk_s2_q, data_s1_q, data_s2_q;
  logic                    filt_clk_q, filt_clk_d, filt_prev_q;
  logic [FILTER_WIDTH-1:0] filt_cnt_q, filt_cnt_d;
  logic [2:0]              state_q, state_d;
  logic [7:0]              byte_q, byte_d;
  logic                    parity_q, parity_d;
  logic [2:0]              bit_idx_q, bit_idx_d;
  logic [INH_W-1:0]        inh_cnt_q, inh_cnt_d;
  logic [TO_W-1:0]         to_cnt_q, to_cnt_d;
  logic                    clk_oe_q, clk_oe_d, data_oe_q, data_oe_d;
  logic                    ready_q, ready_d, done_q, done_d, err_q, err_d;
  logic                    fall, in_xfer;

  assign fall    = filt_prev_q & ~filt_clk_q;
  assign in_xfer = (state_q != ST_IDLE) && (state_q != ST_INHIBIT);

  // The filtered clock follows the synced level only after it has differed
  // for 2**FILTER_WIDTH-1 consecutive cycles.
  always_comb begin
    filt_clk_d = filt_clk_q;
    filt_cnt_d = '0;
    if (clk_s2_q != filt_clk_q) begin
      if (filt_cnt_q == FILT_LAST) begin
        filt_clk_d = clk_s2_q;
      end else begin
        filt_cnt_d = filt_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    byte_d    = byte_q;
    parity_d  = parity_q;
    bit_idx_d = bit_idx_q;
    inh_cnt_d = '0;
    to_cnt_d  = '0;
    done_d    = 1'b0;
    err_d     = 1'b0;

    if (in_xfer) begin
      to_cnt_d = fall ? '0 : to_cnt_q + 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        bit_idx_d = '0;
        if (tx_valid) begin
          byte_d   = tx_data;
          parity_d = ~^tx_data;
          state_d  = ST_INHIBIT;
        end
      end
      ST_INHIBIT: begin
        if (inh_cnt_q == INH_LAST) begin
          state_d = ST_START;
        end else begin
          inh_cnt_d = inh_cnt_q + 1'b1;
        end
      end
      ST_START: begin
        if (fall) begin
          bit_idx_d = '0;
          state_d   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (fall) begin
          if (bit_idx_q == 3'd7) begin
            state_d = ST_PARITY;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
      ST_PARITY: if (fall) state_d = ST_STOP;
      ST_STOP:   if (fall) state_d = ST_ACK;
      ST_ACK: begin
        if (fall) begin
          if (!data_s2_q) begin
            state_d = ST_WAIT_IDLE;
          end else begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      ST_WAIT_IDLE: begin
        if (filt_clk_q && data_s2_q) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A silent device aborts the transfer; this overrides any done pulse.
    if (in_xfer && !fall && (to_cnt_q == TO_LAST)) begin
      state_d = ST_IDLE;
      done_d  = 1'b0;
      err_d   = 1'b1;
    end

    ready_d   = (state_d == ST_IDLE);
    clk_oe_d  = (state_d == ST_INHIBIT);
    data_oe_d = 1'b0;
    case (state_d)
      ST_START:  data_oe_d = 1'b1;
      ST_DATA:   data_oe_d = ~byte_d[bit_idx_d];
      ST_PARITY: data_oe_d = ~parity_d;
      default:   data_oe_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_s1_q    <= 1'b1;
      clk_s2_q    <= 1'b1;
      data_s1_q   <= 1'b1;
      data_s2_q   <= 1'b1;
      filt_clk_q  <= 1'b1;
      filt_prev_q <= 1'b1;
      filt_cnt_q  <= '0;
      state_q     <= ST_IDLE;
      byte_q      <= '0;
      parity_q    <= 1'b0;
      bit_idx_q   <= '0;
      inh_cnt_q   <= '0;
      to_cnt_q    <= '0;
      clk_oe_q    <= 1'b0;
      data_oe_q   <= 1'b0;
      ready_q     <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      clk_s1_q    <= ps2_clk_in;
      clk_s2_q    <= clk_s1_q;
      data_s1_q   <= ps2_data_in;
      data_s2_q   <= data_s1_q;
      filt_clk_q  <= filt_clk_d;
      filt_prev_q <= filt_clk_q;
      filt_cnt_q  <= filt_cnt_d;
      state_q     <= state_d;
      byte_q      <= byte_d;
      parity_q    <= parity_d;
      bit_idx_q   <= bit_idx_d;
      inh_cnt_q   <= inh_cnt_d;
      to_cnt_q    <= to_cnt_d;
      clk_oe_q    <= clk_oe_d;
      data_oe_q   <= data_oe_d;
      ready_q     <= ready_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign tx_ready    = ready_q;
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign done        = done_q;
  assign err         = err_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_tx.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module   : tb_ps2_tx
// Brief    : Directed bench for ps2_tx with a behavioural PS/2 device model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_tx;

  localparam int INH = 16;
  localparam int TO  = 1000;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready, ps2_clk_oe, ps2_data_oe, done, err;
  logic       dev_clk, dev_data;
  logic       clk_line, data_line;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int last_fall_cyc = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;

  // Open-drain lines: low if either side pulls.
  assign clk_line  = dev_clk & ~ps2_clk_oe;
  assign data_line = dev_data & ~ps2_data_oe;

  ps2_tx #(
    .INHIBIT_CYCLES(INH),
    .FILTER_WIDTH  (2),
    .TIMEOUT_CYCLES(TO)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .ps2_clk_in (clk_line),
    .ps2_data_in(data_line),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (done) done_cnt <= done_cnt + 1;
    if (err) err_cnt <= err_cnt + 1;
    if (done && err) both_cnt <= both_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Request a byte, then count the clock-inhibit cycles until START.
  task automatic send(input logic [7:0] b);
    int n;
    @(negedge clk);
    check("ready_before_send", tx_ready, 1);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    n = 0;
    while (ps2_clk_oe && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("inhibit_len", n, INH);
    check("start_bit_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'b01);
  endtask

  // Device: 40-clk PS/2 clock period, samples data on each rising edge.
  // Pulses 1..10 carry data/parity/stop, 11 ends the frame, 12 is the ACK clock.
  task automatic device(input int npulse, input bit do_ack, input bit glitch,
                        output logic [9:0] rx);
    rx = '0;
    for (int i = 0; i < npulse; i++) begin
      if (i == 11) dev_data = ~do_ack;
      if (glitch) begin
        repeat (10) @(negedge clk);
        dev_clk = 1'b0;
        @(negedge clk);
        dev_clk = 1'b1;
        repeat (9) @(negedge clk);
      end else begin
        repeat (20) @(negedge clk);
      end
      dev_clk       = 1'b0;
      last_fall_cyc = cyc;
      repeat (20) @(negedge clk);
      dev_clk = 1'b1;
      if (i < 10) rx = {data_line, rx[9:1]};
    end
    dev_data = 1'b1;
  endtask

  task automatic wait_done(input int exp_done);
    int n;
    n = 0;
    while (done_cnt != exp_done && n < 60) begin
      n++;
      @(negedge clk);
    end
    check("done_count", done_cnt, exp_done);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] rx;
    int         n;
    int         lat;

    rst      = 1'b1;
    tx_data  = 8'h00;
    tx_valid = 1'b0;
    dev_clk  = 1'b1;
    dev_data = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", tx_ready, 1);
    check("rst_clk_oe", ps2_clk_oe, 0);
    check("rst_data_oe", ps2_data_oe, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);

    // 0xED: 6 ones -> parity 1
    send(8'hED);
    device(12, 1'b1, 1'b0, rx);
    check("ed_bits", rx[7:0], 8'hED);
    check("ed_parity", rx[8], 1);
    check("ed_stop", rx[9], 1);
    wait_done(1);
    check("ed_err_none", err_cnt, 0);
    check("ed_ready", tx_ready, 1);

    send(8'h01);
    device(12, 1'b1, 1'b0, rx);
    check("01_bits", rx[7:0], 8'h01);
    check("01_parity", rx[8], 0);
    wait_done(2);

    send(8'hFF);
    device(12, 1'b1, 1'b0, rx);
    check("ff_bits", rx[7:0], 8'hFF);
    check("ff_parity", rx[8], 1);
    wait_done(3);

    // Device leaves data high at the ACK clock
    send(8'h96);
    device(12, 1'b0, 1'b0, rx);
    check("nack_bits", rx[7:0], 8'h96);
    check("nack_err", err_cnt, 1);
    repeat (40) @(negedge clk);
    check("nack_no_done", done_cnt, 3);
    check("nack_ready", tx_ready, 1);

    // Device stops after bit 3. err appears 2 sync + 3 filter + 1 edge-detect
    // cycles after the raw fall, plus TO counted cycles.
    send(8'h3C);
    device(4, 1'b1, 1'b0, rx);
    n = 0;
    while (!err && n < 1200) begin
      n++;
      @(negedge clk);
    end
    lat = cyc - last_fall_cyc;
    check("to_err_seen", err, 1);
    check("to_latency", lat, TO + 6);
    check("to_clk_oe", ps2_clk_oe, 0);
    check("to_data_oe", ps2_data_oe, 0);
    @(negedge clk);
    check("to_err_pulse", err_cnt, 2);
    check("to_ready", tx_ready, 1);

    // Reset while in DATA
    send(8'hA5);
    device(3, 1'b1, 1'b0, rx);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid_clk_oe", ps2_clk_oe, 0);
    check("rst_mid_data_oe", ps2_data_oe, 0);
    check("rst_mid_done", done, 0);
    check("rst_mid_err", err, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_ready", tx_ready, 1);
    repeat (50) @(negedge clk);
    check("rst_mid_no_done", done_cnt, 3);
    check("rst_mid_no_err", err_cnt, 2);

    // Clean 0x55 with clock glitches and tx changes mid-transfer
    send(8'h55);
    fork
      device(12, 1'b1, 1'b1, rx);
      begin
        repeat (150) @(negedge clk);
        tx_data  = 8'h00;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
      end
    join
    check("55_bits", rx[7:0], 8'h55);
    check("55_parity", rx[8], 1);
    check("55_stop", rx[9], 1);
    wait_done(4);
    repeat (20) @(negedge clk);
    check("55_no_restart", ps2_clk_oe, 0);
    check("total_err", err_cnt, 2);
    check("no_done_err_overlap", both_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
